// File: rtl/calc_seq.sv
// Operation sequencer for the 16-bit calculator: debounces the execute button,
// captures opcode and operand, drives the external ALU and updates the accumulator.
module calc_seq #(
  parameter int DEB_CYCLES = 500000,
  parameter int ALU_LAT    = 1
) (
  input  logic        clk,
  input  logic        btnu,
  input  logic        btnl,
  input  logic        btnc,
  input  logic        btnr,
  input  logic        btnd,
  input  logic [15:0] sw,
  input  logic [31:0] alu_result,
  output logic [3:0]  alu_op,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [15:0] led,
  output logic        busy,
  output logic        done
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int LW = $clog2(ALU_LAT + 1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES);
  localparam logic [DW-1:0] DEB_PRE  = DW'(DEB_CYCLES - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(ALU_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_EXEC,
    S_WRITE,
    S_WAIT_REL
  } state_t;

  // Bundle layout: {btnd, btnl, btnc, btnr, sw[15:0]}
  logic [19:0] sync1_q;
  logic [19:0] sync2_q;

  logic          btnd_s;
  logic          btnl_s;
  logic          btnc_s;
  logic          btnr_s;
  logic [15:0]   sw_s;

  logic [DW-1:0] deb_cnt_q;
  logic          press_q;
  logic          deb_level;

  state_t        state_q;
  logic [LW-1:0] lat_q;
  logic [15:0]   acc_q;
  logic [15:0]   swq_q;
  logic [3:0]    alu_op_q;
  logic          done_q;

  logic          unused_alu_hi;

  function automatic logic [3:0] enc_op(input logic l, input logic c, input logic r);
    logic [3:0] op;
    case ({l, c, r})
      3'b000:  op = 4'b0000;
      3'b001:  op = 4'b0001;
      3'b010:  op = 4'b0010;
      3'b011:  op = 4'b0110;
      3'b100:  op = 4'b0100;
      3'b101:  op = 4'b1001;
      3'b110:  op = 4'b1010;
      default: op = 4'b0101;
    endcase
    return op;
  endfunction

  always_ff @(posedge clk) begin
    if (btnu) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {btnd, btnl, btnc, btnr, sw};
      sync2_q <= sync1_q;
    end
  end

  assign btnd_s = sync2_q[19];
  assign btnl_s = sync2_q[18];
  assign btnc_s = sync2_q[17];
  assign btnr_s = sync2_q[16];
  assign sw_s   = sync2_q[15:0];

  // press fires once, on the edge the saturating count first reaches DEB_CYCLES
  always_ff @(posedge clk) begin
    if (btnu) begin
      deb_cnt_q <= '0;
      press_q   <= 1'b0;
    end else if (!btnd_s) begin
      deb_cnt_q <= '0;
      press_q   <= 1'b0;
    end else if (deb_cnt_q != DEB_MAX) begin
      deb_cnt_q <= deb_cnt_q + DW'(1);
      press_q   <= (deb_cnt_q == DEB_PRE);
    end else begin
      press_q   <= 1'b0;
    end
  end

  assign deb_level = (deb_cnt_q == DEB_MAX);

  always_ff @(posedge clk) begin
    if (btnu) begin
      state_q  <= S_IDLE;
      lat_q    <= '0;
      acc_q    <= '0;
      swq_q    <= '0;
      alu_op_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (press_q) state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          alu_op_q <= enc_op(btnl_s, btnc_s, btnr_s);
          swq_q    <= sw_s;
          lat_q    <= '0;
          state_q  <= S_EXEC;
        end
        S_EXEC: begin
          if (lat_q == LAT_LAST) begin
            state_q <= S_WRITE;
            done_q  <= 1'b1;
          end else begin
            lat_q <= lat_q + LW'(1);
          end
        end
        S_WRITE: begin
          acc_q   <= alu_result[15:0];
          state_q <= S_WAIT_REL;
        end
        S_WAIT_REL: begin
          if (!deb_level) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign unused_alu_hi = ^alu_result[31:16];

  assign alu_op = alu_op_q;
  assign op_a   = {{16{acc_q[15]}}, acc_q};
  assign op_b   = {{16{swq_q[15]}}, swq_q};
  assign led    = acc_q;
  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;

endmodule
